// File: rtl/toggle_mailbox_if.sv
// -----------------------------------------------------------------------------
// toggle_mailbox_if
// Bundles the producer/consumer toggle handshakes, the flush control and the
// status outputs of toggle_mailbox.
//   master : drives put_req/put_data, get_req and flush; observes acks/status
//   slave  : the mailbox; drives put_ack, get_ack, get_data, count, full,
//            empty and high_water
// -----------------------------------------------------------------------------
interface toggle_mailbox_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             put_req;
  logic [WIDTH-1:0] put_data;
  logic             put_ack;
  logic             get_req;
  logic             get_ack;
  logic [WIDTH-1:0] get_data;
  logic             flush;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic [CW-1:0]    high_water;

  modport master (
    output put_req, put_data, get_req, flush,
    input  put_ack, get_ack, get_data, count, full, empty, high_water
  );

  modport slave (
    input  put_req, put_data, get_req, flush,
    output put_ack, get_ack, get_data, count, full, empty, high_water
  );
endinterface

// File: rtl/toggle_mailbox.sv
// -----------------------------------------------------------------------------
// toggle_mailbox
// DEPTH-entry circular buffer of WIDTH-bit words between one producer and one
// consumer, both using two-phase (toggle) handshakes. A side has a request
// pending while its req and ack levels differ.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : toggle_mailbox_if.slave (handshakes, flush, count/full/empty,
//             high_water)
// -----------------------------------------------------------------------------
module toggle_mailbox #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  toggle_mailbox_if.slave   bus
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_high_water;
  logic             r_put_ack;
  logic             r_get_ack;
  logic [WIDTH-1:0] r_get_data;

  logic             w_put_pend;
  logic             w_get_pend;
  logic             w_put_fire;
  logic             w_get_fire;
  logic [CW-1:0]    w_count_nxt;

  assign w_put_pend = bus.put_req ^ r_put_ack;
  assign w_get_pend = bus.get_req ^ r_get_ack;

  // Both decisions use the occupancy at the start of the cycle: a full buffer
  // cannot accept a put on the same edge a get frees a slot, and an empty one
  // cannot deliver the word being written (no bypass).
  assign w_put_fire = !bus.flush && w_put_pend && (r_count != CW'(DEPTH));
  assign w_get_fire = !bus.flush && w_get_pend && (r_count != '0);

  always_comb begin
    // NOTE: default assignment first so every path writes w_count_nxt and no
    // latch is inferred.
    w_count_nxt = r_count;
    if (w_put_fire && !w_get_fire)
      w_count_nxt = r_count + CW'(1);
    else if (w_get_fire && !w_put_fire)
      w_count_nxt = r_count - CW'(1);
  end

  // NOTE: storage has no reset; pointers and count define which entries are
  // valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_put_fire)
      r_mem[r_wptr] <= bus.put_data;
  end

  // NOTE: non-blocking assignments throughout sequential logic so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_high_water <= '0;
      r_put_ack    <= 1'b0;
      r_get_ack    <= 1'b0;
      r_get_data   <= '0;
    end else if (bus.flush) begin
      // Pending requests stay pending: acks and get_data are held.
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_high_water <= '0;
    end else begin
      if (w_put_fire) begin
        r_wptr    <= r_wptr + AW'(1);   // power-of-two depth wraps naturally
        r_put_ack <= ~r_put_ack;
      end
      if (w_get_fire) begin
        r_get_data <= r_mem[r_rptr];
        r_rptr     <= r_rptr + AW'(1);
        r_get_ack  <= ~r_get_ack;
      end
      r_count <= w_count_nxt;
      if (w_count_nxt > r_high_water)
        r_high_water <= w_count_nxt;
    end
  end

  assign bus.put_ack    = r_put_ack;
  assign bus.get_ack    = r_get_ack;
  assign bus.get_data   = r_get_data;
  assign bus.count      = r_count;
  assign bus.high_water = r_high_water;
  assign bus.full       = (r_count == CW'(DEPTH));
  assign bus.empty      = (r_count == '0);

endmodule

// File: tb/tb_toggle_mailbox.sv
// -----------------------------------------------------------------------------
// tb_toggle_mailbox
// Drives the mailbox through its interface with directed scenarios followed by
// randomized traffic, comparing every output each cycle against a queue-based
// reference model of the mailbox's behaviour.
// -----------------------------------------------------------------------------
module tb_toggle_mailbox;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  toggle_mailbox_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  toggle_mailbox #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_q [$];
  logic             m_put_ack;
  logic             m_get_ack;
  logic [WIDTH-1:0] m_get_data;
  int               m_hw;

  task automatic model_reset();
    m_q.delete();
    m_put_ack  = 1'b0;
    m_get_ack  = 1'b0;
    m_get_data = '0;
    m_hw       = 0;
  endtask

  // One rising edge worth of mailbox behaviour, from the inputs held over it.
  task automatic model_edge();
    bit put_pend, get_pend, do_put, do_get;
    int n;
    if (bus.flush) begin
      m_q.delete();
      m_hw = 0;
    end else begin
      n        = m_q.size();
      put_pend = (bus.put_req != m_put_ack);
      get_pend = (bus.get_req != m_get_ack);
      do_get   = get_pend && (n > 0);
      do_put   = put_pend && (n < DEPTH);
      if (do_get) begin
        m_get_data = m_q.pop_front();
        m_get_ack  = ~m_get_ack;
      end
      if (do_put) begin
        m_q.push_back(bus.put_data);
        m_put_ack = ~m_put_ack;
      end
      if (m_q.size() > m_hw) m_hw = m_q.size();
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"},    32'(bus.count),      32'(m_q.size()));
    check({tag, ".full"},     32'(bus.full),       32'(m_q.size() == DEPTH));
    check({tag, ".empty"},    32'(bus.empty),      32'(m_q.size() == 0));
    check({tag, ".hw"},       32'(bus.high_water), 32'(m_hw));
    check({tag, ".put_ack"},  32'(bus.put_ack),    32'(m_put_ack));
    check({tag, ".get_ack"},  32'(bus.get_ack),    32'(m_get_ack));
    check({tag, ".get_data"}, 32'(bus.get_data),   32'(m_get_data));
  endtask

  // Inputs change only at negedge; the model is stepped at posedge and the
  // DUT is compared at the following negedge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic post(input logic [WIDTH-1:0] d);
    bus.put_data = d;
    bus.put_req  = ~bus.put_req;
  endtask

  task automatic request();
    bus.get_req = ~bus.get_req;
  endtask

  initial begin
    bus.put_req  = 1'b0;
    bus.put_data = '0;
    bus.get_req  = 1'b0;
    bus.flush    = 1'b0;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    reset_n = 1'b1;

    // 1: three sequential put/get pairs, single-cycle latency each
    for (int d = 1; d <= 3; d++) begin
      post(WIDTH'(d));
      cycle("t1_put");
      check("t1_put_lat", 32'(bus.put_ack), 32'(bus.put_req));
      request();
      cycle("t1_get");
      check("t1_get_lat", 32'(bus.get_ack), 32'(bus.get_req));
      check("t1_data", 32'(bus.get_data), 32'(d));
    end
    check("t1_count0", 32'(bus.count), 32'd0);

    // 2: overfill by one, producer blocks until a get frees a slot
    for (int i = 0; i < 5; i++) begin
      post(WIDTH'(8'hA0 + i));
      cycle("t2_fill");
    end
    check("t2_full", 32'(bus.full), 32'd1);
    check("t2_hw", 32'(bus.high_water), 32'd4);
    check("t2_put_blocked", 32'(bus.put_ack ^ bus.put_req), 32'd1);
    request();
    cycle("t2_get");
    check("t2_first", 32'(bus.get_data), 32'hA0);
    check("t2_put_still_blocked", 32'(bus.put_ack ^ bus.put_req), 32'd1);
    cycle("t2_late_put");
    check("t2_put_done", 32'(bus.put_ack ^ bus.put_req), 32'd0);
    for (int i = 1; i < 5; i++) begin
      request();
      cycle("t2_drain");
      check("t2_order", 32'(bus.get_data), 32'(8'hA0 + i));
    end

    // 3: get while empty waits; no same-edge bypass
    request();
    cycle("t3_wait");
    check("t3_get_blocked", 32'(bus.get_ack ^ bus.get_req), 32'd1);
    post(8'h5C);
    cycle("t3_put");
    check("t3_put_done", 32'(bus.put_ack ^ bus.put_req), 32'd0);
    check("t3_no_bypass", 32'(bus.get_ack ^ bus.get_req), 32'd1);
    cycle("t3_get");
    check("t3_get_done", 32'(bus.get_ack ^ bus.get_req), 32'd0);
    check("t3_data", 32'(bus.get_data), 32'h5C);

    // 4: simultaneous put/get at count 2 and at count 4
    post(8'h21); cycle("t4_a");
    post(8'h22); cycle("t4_b");
    post(8'h23); request();
    cycle("t4_both");
    check("t4_both_put", 32'(bus.put_ack ^ bus.put_req), 32'd0);
    check("t4_both_get", 32'(bus.get_ack ^ bus.get_req), 32'd0);
    check("t4_count2", 32'(bus.count), 32'd2);
    post(8'h24); cycle("t4_c");
    post(8'h25); cycle("t4_d");
    post(8'h26); request();
    cycle("t4_full_both");
    check("t4_full_get", 32'(bus.get_ack ^ bus.get_req), 32'd0);
    check("t4_full_put_wait", 32'(bus.put_ack ^ bus.put_req), 32'd1);
    cycle("t4_full_put");
    check("t4_full_put_done", 32'(bus.put_ack ^ bus.put_req), 32'd0);
    check("t4_count4", 32'(bus.count), 32'd4);
    for (int i = 0; i < 4; i++) begin request(); cycle("t4_drain"); end

    // 5: eight put/get pairs wrap both pointers
    for (int i = 0; i < 8; i++) begin
      post(WIDTH'(8'h40 + i)); cycle("t5_put");
      request(); cycle("t5_get");
      check("t5_data", 32'(bus.get_data), 32'(8'h40 + i));
    end

    // 6: flush with a pending get, then serve it
    for (int i = 0; i < 3; i++) begin post(WIDTH'(8'h70 + i)); cycle("t6_fill"); end
    request();
    bus.flush = 1'b1;
    cycle("t6_flush");
    bus.flush = 1'b0;
    check("t6_count", 32'(bus.count), 32'd0);
    check("t6_hw", 32'(bus.high_water), 32'd0);
    check("t6_get_pending", 32'(bus.get_ack ^ bus.get_req), 32'd1);
    post(8'h11);
    cycle("t6_put");
    cycle("t6_get");
    check("t6_data", 32'(bus.get_data), 32'h11);

    // asynchronous reset away from the clock edge
    post(8'h99); cycle("t6_pre");
    request();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_put_ack", 32'(bus.put_ack), 32'd0);
    check("arst_get_ack", 32'(bus.get_ack), 32'd0);
    check("arst_get_data", 32'(bus.get_data), 32'd0);
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_hw", 32'(bus.high_water), 32'd0);
    check("arst_empty", 32'(bus.empty), 32'd1);
    check("arst_full", 32'(bus.full), 32'd0);
    bus.put_req = 1'b0;
    bus.get_req = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // randomized traffic: bias shifts from producer-heavy to consumer-heavy
    for (int c = 0; c < 2000; c++) begin
      int put_pct = (c < 1000) ? 70 : 30;
      if (bus.put_req == m_put_ack && $urandom_range(99, 0) < put_pct)
        post(WIDTH'($urandom));
      if (bus.get_req == m_get_ack && $urandom_range(99, 0) < 100 - put_pct)
        request();
      bus.flush = ($urandom_range(59, 0) == 0);
      cycle("rnd");
    end
    bus.flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/toggle_mailbox.md
Name: toggle_mailbox

Overview:
- Parametrised, synthesisable mailbox between one producer and one consumer, both synchronous to `clk`.
- Both sides use a toggle (two-phase) handshake: a request is pending whenever its req and ack levels differ.
- Replaces the single-byte, depth-1 shared-variable exchange with a DEPTH-entry circular buffer of WIDTH-bit words.
- Adds occupancy reporting, a sticky high-water mark and a synchronous flush.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, buffer entries; power of two, >=2
CW, $clog2(DEPTH)+1, width of count outputs (derived; not overridden)

Ports:
clk  input  1  single clock; all logic on the rising edge
reset_n  input  1  asynchronous, active-low reset
put_req  input  1  producer toggle; flipping it while put_req==put_ack posts put_data
put_data  input  WIDTH  producer word; held stable while put request is pending
put_ack  output  1  toggles once when the posted word is written into the buffer
get_req  input  1  consumer toggle; flipping it while get_req==get_ack requests one word
get_ack  output  1  toggles once when get_data holds the requested word
get_data  output  WIDTH  last delivered word; held until the next delivery
flush  input  1  synchronous clear of buffer contents
count  output  CW  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
empty  output  1  count==0
high_water  output  CW  maximum count reached since reset or flush

Behaviour:
- Reset (reset_n low, asynchronous):
  - put_ack=0, get_ack=0, get_data=0, count=0, high_water=0, full=0, empty=1.
  - Read and write pointers = 0.
  - A reset mid-transfer abandons it; requesters must also return req to 0.
- Pending conditions:
  - put_pend = put_req ^ put_ack.
  - get_pend = get_req ^ get_ack.
  - Inputs are already synchronous to `clk`; no synchroniser is included.
- Put service:
  - Fires on a rising edge where put_pend=1 and count<DEPTH, using count at the start of the cycle.
  - Action: mem[wptr] <= put_data, wptr wraps modulo DEPTH, put_ack <= ~put_ack.
  - Earliest put_ack toggle is the first edge after put_req toggles (1-cycle latency).
- Get service:
  - Fires on a rising edge where get_pend=1 and count>0.
  - Action: get_data <= mem[rptr], rptr wraps modulo DEPTH, get_ack <= ~get_ack.
  - No bypass: a word written on edge N is deliverable no earlier than edge N+1.
- Full: put_pend stays high and put_ack does not toggle (producer blocks). The put is serviced on the first edge where count<DEPTH.
- Empty: get_pend stays high and get_ack does not toggle (consumer blocks).
- Simultaneous put and get on one edge:
  - Both fire if their conditions hold; count is unchanged.
  - When full, only the get fires that edge; the put fires on the next edge.
  - When empty, only the put fires.
- count: +1 on put only, -1 on get only, unchanged on both or neither. full and empty are combinational from count.
- high_water: updates to the new count whenever it exceeds the stored value; never decreases except on reset or flush.
- flush=1 on an edge:
  - Pointers and count go to 0; high_water goes to 0.
  - No put or get fires that edge; put_ack, get_ack and get_data are held.
  - Pending requests remain pending and are serviced normally afterwards.
- Protocol: the requester must not toggle req again while pending. Behaviour in that case is undefined and is not checked.

Test Plan:
- Reset then 3 sequential put/get pairs with data 1,2,3 → each put_ack toggles 1 cycle after put_req; each get_ack toggles 1 cycle after get_req; get_data = 1,2,3; count returns to 0.
- DEPTH=4: post 5 puts (0xA0..0xA4) with no gets → 4 acks, put_pend held on the 5th, full=1, high_water=4. One get delivers 0xA0; the 5th put_ack toggles on the following edge.
- Get request while empty, then a put of 0x5C → put_ack on edge N, get_ack on edge N+1 with get_data=0x5C; never the same edge.
- count=2 with put and get pending on the same edge → both acks toggle together; count stays 2. At count=4 with both pending → get fires, put fires one edge later.
- 8 sequential puts and gets with DEPTH=4 → pointer wrap is correct and data order is preserved (FIFO).
- Flush at count=3 with a get pending → count=0, high_water=0, no get_ack. A later put of 0x11 is delivered to the still-pending get. Assert reset_n low mid-pending → all outputs at reset values immediately, without waiting for a clock edge.
